// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Parameter defaults used by the controller top.
    localparam int NREG_DEF     = 32;
    localparam int ZERO_REG_DEF = 1;
    localparam int NSTG_DEF     = 3;
    localparam int CNT_W_DEF    = 32;

    // EX operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Data-memory wait tracking.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all ones instead of wrapping.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until the all-ones value, then hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding selects, load-use stall, memory freeze and branch flush control.
// Latency: all control outputs combinational; counters lag their event by one clock.
// Backpressure: freeze (data memory not ready) dominates; a branch seen while frozen is held until unfrozen.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int   NREG     = NREG_DEF,
    parameter int   ZERO_REG = ZERO_REG_DEF,
    parameter int   NSTG     = NSTG_DEF,
    parameter int   CNT_W    = CNT_W_DEF,
    localparam int  REGW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REGW-1:0]  id_rs1,
    input  logic [REGW-1:0]  id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REGW-1:0]  ex_rs1,
    input  logic [REGW-1:0]  ex_rs2,
    input  logic [REGW-1:0]  ex_rd,
    input  logic [REGW-1:0]  mem_rd,
    input  logic [REGW-1:0]  wb_rd,
    input  logic             ex_regwrite,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             ex_memread,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             br_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_fe,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [NSTG-1:0]  flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e   state_q;
    state_e   state_d;
    logic     br_pend_q;
    logic     br_pend_d;
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;
    logic     mem_live;
    logic     wb_live;
    logic     ex_live;
    logic     load_use;
    logic     freeze_w;
    logic     flush_evt;
    logic     stall_w;

    // A destination register is a real producer unless it is the hardwired zero.
    assign mem_live = !((ZERO_REG != 0) && (mem_rd == '0));
    assign wb_live  = !((ZERO_REG != 0) && (wb_rd == '0));
    assign ex_live  = !((ZERO_REG != 0) && (ex_rd == '0));

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (mem_regwrite && mem_live && (mem_rd == ex_rs1)) begin
            fwd_a_sel = FWD_MEM;
        end else if (wb_regwrite && wb_live && (wb_rd == ex_rs1)) begin
            fwd_a_sel = FWD_WB;
        end
        if (mem_regwrite && mem_live && (mem_rd == ex_rs2)) begin
            fwd_b_sel = FWD_MEM;
        end else if (wb_regwrite && wb_live && (wb_rd == ex_rs2)) begin
            fwd_b_sel = FWD_WB;
        end
    end

    assign fwd_a = fwd_a_sel;
    assign fwd_b = fwd_b_sel;

    // The loaded value is not available in time for a dependent instruction in ID.
    // ex_regwrite is not required: a load always writes its destination.
    assign load_use = ex_memread && ex_live &&
                      ((id_use1 && (ex_rd == id_rs1)) ||
                       (id_use2 && (ex_rd == id_rs2)));

    // State and pending-branch registers; reset discards any wait or pending flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            br_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_pend_q <= br_pend_d;
        end
    end

    // Next state plus the freeze > flush > load-use priority resolution.
    always_comb begin
        state_d   = state_q;
        br_pend_d = br_pend_q;
        freeze_w  = 1'b0;
        flush_evt = 1'b0;
        stall_w   = 1'b0;

        case (state_q)
            RUN:      if (mem_req && !dmem_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready)             state_d = RUN;
            default:                              state_d = RUN;
        endcase

        // Outputs are forced quiet while reset is held, whatever the inputs do.
        if (reset) begin
            if (mem_req && !dmem_ready) begin
                freeze_w = 1'b1;
                // Remember the branch; it flushes once the pipe can move again.
                if (br_taken) begin
                    br_pend_d = 1'b1;
                end
            end else if (br_taken || br_pend_q) begin
                // A pending branch and a fresh one in the same cycle are one flush.
                flush_evt = 1'b1;
                br_pend_d = 1'b0;
            end else if (load_use) begin
                stall_w = 1'b1;
            end
        end
    end

    assign freeze    = freeze_w;
    assign stall_fe  = stall_w;
    assign bubble_ex = stall_w;
    assign flush     = {NSTG{flush_evt}};

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_w || freeze_w),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int REGW  = 5;
    localparam int NSTG  = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk;
    logic             reset;
    logic [REGW-1:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             id_use1, id_use2;
    logic             ex_regwrite, mem_regwrite, wb_regwrite;
    logic             ex_memread, mem_req, dmem_ready, br_taken;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_fe, bubble_ex, freeze;
    logic [NSTG-1:0]  flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.NREG(32), .ZERO_REG(1), .NSTG(NSTG), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .mem_req(mem_req), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_fe(stall_fe), .bubble_ex(bubble_ex),
        .freeze(freeze), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ex_rs1, ex_rs2, mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       ld;
        logic [4:0] ex_rd, id_rs1;
        logic       use1;
        logic [4:0] id_rs2;
        logic       use2;
        logic       br;
        logic [1:0] fa, fb;
        logic       stl;
        logic [2:0] fl;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic [4:0] a_mrd,
                       input logic a_mwe, input logic [4:0] a_wrd, input logic a_wwe,
                       input logic a_ld, input logic [4:0] a_exrd, input logic [4:0] a_id1,
                       input logic a_u1, input logic [4:0] a_id2, input logic a_u2, input logic a_br,
                       input logic [1:0] e_fa, input logic [1:0] e_fb, input logic e_stl,
                       input logic [2:0] e_fl);
        vec_t v;
        v.ex_rs1 = a_rs1; v.ex_rs2 = a_rs2; v.mem_rd = a_mrd; v.mem_we = a_mwe;
        v.wb_rd = a_wrd; v.wb_we = a_wwe; v.ld = a_ld; v.ex_rd = a_exrd;
        v.id_rs1 = a_id1; v.use1 = a_u1; v.id_rs2 = a_id2; v.use2 = a_u2; v.br = a_br;
        v.fa = e_fa; v.fb = e_fb; v.stl = e_stl; v.fl = e_fl;
        vt.push_back(v);
    endtask

    task automatic clear_in();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_use1 = 1'b0; id_use2 = 1'b0; ex_regwrite = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        ex_memread = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b0;
        next();
        reset = 1'b1;
    endtask

    task automatic set_load_use();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use2 = 1'b1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] mrd, input logic mwe,
                                           input logic [4:0] wrd, input logic wwe);
        if (mwe && mrd != 0 && mrd == rs) return 2'b10;
        if (wwe && wrd != 0 && wrd == rs) return 2'b01;
        return 2'b00;
    endfunction

    int m_pend, m_sc, m_fc;

    initial begin
        reset = 1'b0;
        clear_in();
        #2;
        chk("rst_freeze", 32'(freeze), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        next();

        // Single-cycle vectors (mem_req stays 0, so nothing freezes).
        add(5'd5,5'd0,5'd5,1'b1,5'd5,1'b1, 1'b0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0, 2'd2,2'd0,1'b0,3'd0);
        add(5'd5,5'd0,5'd5,1'b0,5'd5,1'b1, 1'b0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0, 2'd1,2'd0,1'b0,3'd0);
        add(5'd0,5'd0,5'd0,1'b1,5'd0,1'b1, 1'b0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0, 2'd0,2'd0,1'b0,3'd0);
        add(5'd3,5'd9,5'd9,1'b1,5'd3,1'b1, 1'b0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0, 2'd1,2'd2,1'b0,3'd0);
        add(5'd3,5'd3,5'd3,1'b0,5'd3,1'b1, 1'b0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0, 2'd1,2'd1,1'b0,3'd0);
        add(5'd3,5'd3,5'd3,1'b0,5'd3,1'b0, 1'b0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0, 2'd0,2'd0,1'b0,3'd0);
        add(5'd4,5'd4,5'd4,1'b1,5'd4,1'b1, 1'b0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0, 2'd2,2'd2,1'b0,3'd0);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b1,5'd7,5'd1,1'b1,5'd7,1'b1, 1'b0, 2'd0,2'd0,1'b1,3'd0);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b1,5'd7,5'd1,1'b1,5'd7,1'b0, 1'b0, 2'd0,2'd0,1'b0,3'd0);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b1,5'd7,5'd7,1'b1,5'd2,1'b1, 1'b0, 2'd0,2'd0,1'b1,3'd0);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b1,5'd7,5'd7,1'b0,5'd7,1'b0, 1'b0, 2'd0,2'd0,1'b0,3'd0);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b1,5'd0,5'd0,1'b1,5'd0,1'b1, 1'b0, 2'd0,2'd0,1'b0,3'd0);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b0,5'd7,5'd7,1'b1,5'd7,1'b1, 1'b0, 2'd0,2'd0,1'b0,3'd0);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b1,5'd7,5'd0,1'b0,5'd7,1'b1, 1'b1, 2'd0,2'd0,1'b0,3'd7);
        add(5'd0,5'd0,5'd0,1'b0,5'd0,1'b0, 1'b1,5'd7,5'd0,1'b0,5'd7,1'b1, 1'b0, 2'd0,2'd0,1'b1,3'd0);

        reset = 1'b1;
        foreach (vt[i]) begin
            clear_in();
            ex_rs1 = vt[i].ex_rs1; ex_rs2 = vt[i].ex_rs2; mem_rd = vt[i].mem_rd;
            mem_regwrite = vt[i].mem_we; wb_rd = vt[i].wb_rd; wb_regwrite = vt[i].wb_we;
            ex_memread = vt[i].ld; ex_regwrite = vt[i].ld; ex_rd = vt[i].ex_rd;
            id_rs1 = vt[i].id_rs1; id_use1 = vt[i].use1; id_rs2 = vt[i].id_rs2; id_use2 = vt[i].use2;
            br_taken = vt[i].br;
            #1;
            chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a), 32'(vt[i].fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b), 32'(vt[i].fb));
            chk($sformatf("vec%0d_stall_fe", i), 32'(stall_fe), 32'(vt[i].stl));
            chk($sformatf("vec%0d_bubble_ex", i), 32'(bubble_ex), 32'(vt[i].stl));
            chk($sformatf("vec%0d_freeze", i), 32'(freeze), 0);
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vt[i].fl));
            next();
        end

        // Load-use alone: one stall cycle counted.
        do_reset();
        set_load_use();
        #1;
        chk("lu_stall_fe", 32'(stall_fe), 1);
        chk("lu_bubble_ex", 32'(bubble_ex), 1);
        chk("lu_cnt_before", 32'(stall_cnt), 0);
        next();
        clear_in();
        #1;
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        chk("lu_stall_fe_off", 32'(stall_fe), 0);

        // Load-use with a taken branch: branch wins.
        do_reset();
        set_load_use();
        br_taken = 1'b1;
        #1;
        chk("lubr_flush", 32'(flush), 7);
        chk("lubr_stall_fe", 32'(stall_fe), 0);
        next();
        clear_in();
        #1;
        chk("lubr_flush_cnt", 32'(flush_cnt), 1);
        chk("lubr_stall_cnt", 32'(stall_cnt), 0);

        // Four frozen cycles, branch in cycle 2 (load-use in cycle 3 is masked),
        // then an unfrozen cycle that also carries a fresh branch: one flush only.
        do_reset();
        mem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            br_taken = (c == 2);
            if (c == 3) set_load_use();
            else begin ex_memread = 1'b0; id_use2 = 1'b0; end
            #1;
            chk($sformatf("frz_c%0d_freeze", c), 32'(freeze), 1);
            chk($sformatf("frz_c%0d_flush", c), 32'(flush), 0);
            chk($sformatf("frz_c%0d_stall_fe", c), 32'(stall_fe), 0);
            next();
        end
        mem_req = 1'b0;
        dmem_ready = 1'b1;
        br_taken = 1'b1;
        #1;
        chk("frz_c5_freeze", 32'(freeze), 0);
        chk("frz_c5_flush", 32'(flush), 7);
        next();
        br_taken = 1'b0;
        #1;
        chk("frz_c6_flush", 32'(flush), 0);
        chk("frz_stall_cnt", 32'(stall_cnt), 4);
        chk("frz_flush_cnt", 32'(flush_cnt), 1);

        // Saturation after 20 stall cycles.
        do_reset();
        set_load_use();
        for (int c = 0; c < 20; c++) next();
        clear_in();
        #1;
        chk("sat_stall_cnt", 32'(stall_cnt), CMAX);

        // Reset during a wait with a branch pending.
        do_reset();
        mem_req = 1'b1;
        dmem_ready = 1'b0;
        br_taken = 1'b1;
        next();
        br_taken = 1'b0;
        #1;
        chk("rstw_freeze_pre", 32'(freeze), 1);
        reset = 1'b0;
        br_taken = 1'b1;
        set_load_use();
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1;
        #1;
        chk("rstw_freeze", 32'(freeze), 0);
        chk("rstw_flush", 32'(flush), 0);
        chk("rstw_stall_fe", 32'(stall_fe), 0);
        chk("rstw_bubble_ex", 32'(bubble_ex), 0);
        chk("rstw_stall_cnt", 32'(stall_cnt), 0);
        chk("rstw_fwd_a", 32'(fwd_a), 2);
        next();
        clear_in();
        reset = 1'b1;
        mem_req = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("rstw_rel_flush", 32'(flush), 0);
        chk("rstw_rel_freeze", 32'(freeze), 0);
        next();
        #1;
        chk("rstw_rel_flush2", 32'(flush), 0);
        chk("rstw_flush_cnt", 32'(flush_cnt), 0);

        // Randomized run against a rule-level model.
        do_reset();
        m_pend = 0; m_sc = 0; m_fc = 0;
        for (int n = 0; n < 3000; n++) begin
            logic frz, fl, lu, st;
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_use1 = 1'($urandom_range(0, 1)); id_use2 = 1'($urandom_range(0, 1));
            ex_regwrite = 1'($urandom_range(0, 1)); mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite = 1'($urandom_range(0, 1)); ex_memread = 1'($urandom_range(0, 1));
            mem_req = ($urandom_range(0, 2) == 0);
            dmem_ready = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 99) != 0);
            if (!reset) begin m_pend = 0; m_sc = 0; m_fc = 0; end
            #1;
            frz = reset && mem_req && !dmem_ready;
            fl  = reset && !frz && (br_taken || m_pend != 0);
            lu  = ex_memread && ex_rd != 0 &&
                  ((id_use1 && ex_rd == id_rs1) || (id_use2 && ex_rd == id_rs2));
            st  = reset && !frz && !fl && lu;
            chk("rnd_fwd_a", 32'(fwd_a), 32'(ref_fwd(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite)));
            chk("rnd_fwd_b", 32'(fwd_b), 32'(ref_fwd(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite)));
            chk("rnd_freeze", 32'(freeze), 32'(frz));
            chk("rnd_flush", 32'(flush), fl ? 7 : 0);
            chk("rnd_stall_fe", 32'(stall_fe), 32'(st));
            chk("rnd_bubble_ex", 32'(bubble_ex), 32'(st));
            chk("rnd_stall_cnt", 32'(stall_cnt), m_sc);
            chk("rnd_flush_cnt", 32'(flush_cnt), m_fc);
            next();
            if (reset) begin
                m_pend = frz ? ((m_pend != 0 || br_taken) ? 1 : 0) : 0;
                if ((st || frz) && m_sc < CMAX) m_sc++;
                if (fl && m_fc < CMAX) m_fc++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NREG, default 32: architectural register count; REGW = clog2(NREG).
REQ-002 Parameter ZERO_REG, default 1: when 1, register index 0 never forwards and never causes a hazard.
REQ-003 Parameter NSTG, default 3: number of pipeline registers flushed on a taken branch (IF/ID=bit0, ID/EX=bit1, EX/MEM=bit2, ...).
REQ-004 Parameter CNT_W, default 32: width of each performance counter.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-low reset.
REQ-007 Port id_rs1, id_rs2  in  REGW  source registers of the instruction in ID; id_use1, id_use2  in  1  source is actually read.
REQ-008 Port ex_rs1, ex_rs2  in  REGW  source registers of the instruction in EX.
REQ-009 Port ex_rd, mem_rd, wb_rd  in  REGW  destination registers; ex_regwrite, mem_regwrite, wb_regwrite  in  1  write enables.
REQ-010 Port ex_memread  in  1  EX instruction is a load; mem_req  in  1  MEM instruction accesses data memory; dmem_ready  in  1  data memory completes this cycle.
REQ-011 Port br_taken  in  1  taken branch resolved in the EX/MEM stage.
REQ-012 Port fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 MEM/WB result, 10 EX/MEM result.
REQ-013 Port stall_fe  out  1  hold PC and IF/ID; bubble_ex  out  1  load zeros/NOP into ID/EX.
REQ-014 Port freeze  out  1  hold every pipeline register and PC; flush  out  NSTG  clear the selected pipeline registers.
REQ-015 Port stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Function
REQ-016 fwd_a SHALL be 10 when mem_regwrite and mem_rd==ex_rs1 (and mem_rd!=0 if ZERO_REG); otherwise 01 under the same test on wb_*; otherwise 00; fwd_b SHALL follow the same rule on ex_rs2; combinational.
REQ-017 Load-use SHALL be ex_memread and ex_rd matching id_rs1 (id_use1) or id_rs2 (id_use2), with the x0 exclusion; when set and not frozen, stall_fe=1 and bubble_ex=1 in that cycle.
REQ-018 FSM states SHALL be RUN and MEM_WAIT; RUN->MEM_WAIT when mem_req and !dmem_ready; MEM_WAIT->RUN on the cycle dmem_ready=1.
REQ-019 freeze SHALL equal (mem_req and !dmem_ready), combinationally, in both states.
REQ-020 The priority SHALL be freeze > flush > load-use; while freeze=1, stall_fe, bubble_ex and flush SHALL be 0.
REQ-021 br_taken with freeze=0 SHALL drive flush to all ones in the same cycle and SHALL override load-use.
REQ-022 br_taken with freeze=1 SHALL set a br_pend flag; flush SHALL be all ones in the first unfrozen cycle, then br_pend clears; a new br_taken in that cycle SHALL NOT double-count.
REQ-023 stall_cnt SHALL increment on every cycle with stall_fe=1 or freeze=1; flush_cnt SHALL increment once per flush event; both SHALL saturate at all ones.

Reset
REQ-024 While reset=0: state=RUN, br_pend=0, stall_cnt=0, flush_cnt=0; freeze, stall_fe, bubble_ex=0 and flush=0 regardless of inputs; fwd_a/fwd_b remain combinational.
REQ-025 Reset asserted mid-MEM_WAIT or with br_pend set SHALL discard the pending state; the first cycle after release starts in RUN.

Structure
REQ-026 Package pipe_ctrl_pkg SHALL hold the fwd-select encoding (FWD_RF, FWD_WB, FWD_MEM), the FSM state type and the parameter defaults.
REQ-027 One sub-module sat_counter (parameter W; ports inc, count) SHALL implement both counters.

Verification
REQ-028 ex_rs1=5, mem_rd=5/mem_regwrite=1, wb_rd=5/wb_regwrite=1 -> fwd_a=10; then mem_regwrite=0 -> fwd_a=01; with rd=0 on both -> fwd_a=00.
REQ-029 ex_memread=1, ex_rd=7, id_rs2=7, id_use2=1 -> stall_fe=1, bubble_ex=1 for one cycle; stall_cnt 0->1.
REQ-030 Same load-use plus br_taken=1 -> flush=3'b111, stall_fe=0; flush_cnt=1.
REQ-031 mem_req=1, dmem_ready=0 for 4 cycles with br_taken pulsed in cycle 2 -> freeze high 4 cycles, flush=0 throughout; flush=111 in cycle 5; stall_cnt=4, flush_cnt=1.
REQ-032 CNT_W=4, 20 consecutive stall cycles -> stall_cnt holds 15.
REQ-033 reset=0 during MEM_WAIT with br_pend set -> outputs 0 immediately; after release with dmem_ready=1, no flush occurs.
